// File: rtl/fifo_uart_drain_pkg.sv
// rtl/fifo_uart_drain_pkg.sv - shared state type and default sizes for the FIFO-to-UART drain
// Contents: state_t (drain FSM states), DATO_WIDTH_DEF, CLKS_PER_BIT_DEF.
package fifo_uart_pkg;

   localparam int DATO_WIDTH_DEF   = 8;
   localparam int CLKS_PER_BIT_DEF = 434;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      LOAD,
      START,
      DATA,
      STOP
   } state_t;

endpackage

// File: rtl/fifo_uart_drain_if.sv
// rtl/fifo_uart_drain_if.sv - FIFO read side plus serial line bundle
// Signals: en, empy, datin (towards the drain); rd, tx, busy (from the drain).
// master: FIFO/system side, slave: the drain block.
interface fifo_uart_drain_if
   import fifo_uart_pkg::*;
#(
   parameter int dato_width = DATO_WIDTH_DEF
);
   logic                  en;
   logic                  empy;
   logic [dato_width-1:0] datin;
   logic                  rd;
   logic                  tx;
   logic                  busy;

   modport master (output en, empy, datin, input rd, tx, busy);
   modport slave  (input en, empy, datin, output rd, tx, busy);
endinterface

// File: rtl/fifo_uart_drain_baud_tick.sv
// rtl/fifo_uart_drain_baud_tick.sv - bit-period divider for the UART drain
// Ports: rclk, rst (async, active low), clr (restart the period), tick (last cycle of each bit).
module baud_tick
   import fifo_uart_pkg::*;
#(
   parameter int clks_per_bit = CLKS_PER_BIT_DEF
) (
   input  logic rclk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int            CW   = $clog2(clks_per_bit);
   localparam logic [CW-1:0] LAST = CW'(clks_per_bit - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || cnt_q == LAST) cnt_d = '0;
   end

   // High during the final cycle of a bit so the FSM advances on the bit boundary.
   assign tick = (cnt_q == LAST);

   always_ff @(posedge rclk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
endmodule

// File: rtl/fifo_uart_drain.sv
// rtl/fifo_uart_drain.sv - pops the pixel FIFO one word at a time and sends each word 8N1, LSB first
// Ports: rclk, rst (async, active low), fif (slave: en, empy, datin in; rd, tx, busy out).
module fifo_uart_drain
   import fifo_uart_pkg::*;
#(
   parameter int dato_width   = DATO_WIDTH_DEF,
   parameter int clks_per_bit = CLKS_PER_BIT_DEF
) (
   input logic               rclk,
   input logic               rst,
   fifo_uart_drain_if.slave  fif
);
   localparam int            BW       = $clog2(dato_width + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(dato_width - 1);

   state_t                state_q, state_d;
   logic [dato_width-1:0] shift_q, shift_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  rd_q, rd_d;
   logic                  tx_q, tx_d;
   logic                  tick;
   logic                  baud_clr;

   // Restart the bit period as the start bit goes out, so START is a full bit long.
   assign baud_clr = (state_q == LOAD);

   baud_tick #(.clks_per_bit(clks_per_bit)) u_baud_tick (
      .rclk (rclk),
      .rst  (rst),
      .clr  (baud_clr),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rd_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (fif.en && !fif.empy) begin
               state_d = REQ;
               rd_d    = 1'b1;
            end
         end
         REQ:  state_d = LOAD;
         // FIFO output is registered: the popped word is on datin one cycle after rd.
         LOAD: begin
            state_d = START;
            shift_d = fif.datin;
            tx_d    = 1'b0;
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 1'b1;
               if (bit_q == LAST_BIT) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  tx_d    = shift_d[0];
               end
            end
         end
         STOP: begin
            if (tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge rclk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         rd_q    <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         rd_q    <= rd_d;
         tx_q    <= tx_d;
      end
   end

   assign fif.rd   = rd_q;
   assign fif.tx   = tx_q;
   assign fif.busy = (state_q != IDLE);
endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb/tb_fifo_uart_drain.sv - scoreboard bench for fifo_uart_drain
module tb_fifo_uart_drain;
   localparam int DW    = 8;
   localparam int CPB   = 4;
   localparam int FW    = DW + 2;
   localparam int CPB2  = 434;

   logic rclk = 1'b0;
   logic rst_n = 1'b0;
   always #5 rclk = ~rclk;

   fifo_uart_drain_if #(.dato_width(DW)) ifc ();
   fifo_uart_drain_if #(.dato_width(DW)) ifc2 ();

   fifo_uart_drain #(.dato_width(DW), .clks_per_bit(CPB)) dut (
      .rclk (rclk),
      .rst  (rst_n),
      .fif  (ifc.slave)
   );

   fifo_uart_drain #(.dato_width(DW), .clks_per_bit(CPB2)) dut2 (
      .rclk (rclk),
      .rst  (rst_n),
      .fif  (ifc2.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rd_count = 0;
   int frames_done = 0;
   int last_rd_cyc = -100;

   logic [DW-1:0] fifo[$];
   logic [FW-1:0] exp_q[$];
   int            starts_q[$];

   always @(posedge rclk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // FIFO model: registered read data; each pop queues the expected line frame (start, data LSB first, stop).
   always @(posedge rclk) begin
      logic [DW-1:0] w;
      if (ifc.rd) begin
         n_checks++;
         if (fifo.size() == 0) begin
            n_fail++;
            $display("FAIL rd_when_empty: rd=1 with empty FIFO (cycle %0d)", cyc);
         end else begin
            w = fifo.pop_front();
            ifc.datin <= w;
            exp_q.push_back({1'b1, w, 1'b0});
            rd_count++;
         end
      end
   end

   always @(negedge rclk) ifc.empy = (fifo.size() == 0);

   // Monitor: decodes the serial line and compares against the scoreboard.
   logic          mon_active = 1'b0;
   int            mon_pos = 0;
   logic [FW-1:0] exp_bits;
   logic          bit_bad = 1'b0;
   logic          bad_tx = 1'b0;
   logic          prev_tx = 1'b1;
   logic          prev_rd = 1'b0;

   always @(negedge rclk) begin
      if (!rst_n) begin
         mon_active = 1'b0;
      end else begin
         if (!mon_active && prev_tx && !ifc.tx) begin
            mon_active = 1'b1;
            mon_pos = 0;
            bit_bad = 1'b0;
            starts_q.push_back(cyc);
            chk("start_latency", cyc - last_rd_cyc, 2);
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_frame: start bit with no popped word (cycle %0d)", cyc);
               mon_active = 1'b0;
            end else begin
               exp_bits = exp_q.pop_front();
            end
         end
         if (mon_active) begin
            if (mon_pos == FW * CPB) begin
               chk("busy_after_frame", int'(ifc.busy), 0);
               mon_active = 1'b0;
               frames_done++;
            end else begin
               if (ifc.tx !== exp_bits[mon_pos / CPB] || ifc.busy !== 1'b1) begin
                  if (!bit_bad) bad_tx = ifc.tx;
                  bit_bad = 1'b1;
               end
               if (mon_pos % CPB == CPB - 1) begin
                  n_checks++;
                  if (bit_bad) begin
                     n_fail++;
                     $display("FAIL frame_bit%0d: tx=%0b, expected tx=%0b busy=1 for %0d cycles (cycle %0d)",
                              mon_pos / CPB, bad_tx, exp_bits[mon_pos / CPB], CPB, cyc);
                  end
                  bit_bad = 1'b0;
               end
               mon_pos++;
            end
         end
      end
      prev_tx = ifc.tx;
      if (ifc.rd) begin
         last_rd_cyc = cyc;
         chk("rd_single_cycle", int'(prev_rd), 0);
      end
      prev_rd = ifc.rd;
   end

   // Second FIFO model for the full-rate instance: holds a single word 0x5A.
   logic popped2 = 1'b0;
   always @(posedge rclk) begin
      if (ifc2.rd) begin
         ifc2.datin <= 8'h5A;
         popped2 <= 1'b1;
      end
   end
   always @(negedge rclk) ifc2.empy = popped2;

   task automatic wait_quiet(input string name, input bit need_empty, input int max);
      int n = 0;
      while (!((!need_empty || fifo.size() == 0) && !ifc.busy && !mon_active
               && exp_q.size() == 0) && n < max) begin
         @(negedge rclk);
         n++;
      end
      chk({name, "_timeout"}, int'(n < max), 1);
   endtask

   initial begin
      int n;
      int r0;
      int bad;
      int k;
      logic [FW-1:0] f2;

      ifc.en  = 1'b0;
      ifc2.en = 1'b0;
      rst_n   = 1'b0;
      repeat (3) @(negedge rclk);
      chk("reset_tx", int'(ifc.tx), 1);
      chk("reset_rd", int'(ifc.rd), 0);
      chk("reset_busy", int'(ifc.busy), 0);
      rst_n = 1'b1;

      // Enabled but FIFO empty: nothing happens.
      ifc.en = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge rclk);
         if (ifc.rd || !ifc.tx || ifc.busy) bad++;
      end
      chk("idle_when_empty", bad, 0);
      chk("idle_rd_count", rd_count, 0);

      // Single word 0xA5.
      @(negedge rclk);
      r0 = rd_count;
      fifo.push_back(8'hA5);
      wait_quiet("a5", 1'b1, 200);
      chk("a5_rd_pulses", rd_count - r0, 1);

      // Three back-to-back words.
      @(negedge rclk);
      starts_q.delete();
      r0 = rd_count;
      fifo.push_back(8'h01);
      fifo.push_back(8'h80);
      fifo.push_back(8'hFF);
      wait_quiet("b2b", 1'b1, 400);
      chk("b2b_rd_pulses", rd_count - r0, 3);
      chk("b2b_frames", starts_q.size(), 3);
      if (starts_q.size() == 3) begin
         chk("b2b_spacing1", starts_q[1] - starts_q[0], FW * CPB + 3);
         chk("b2b_spacing2", starts_q[2] - starts_q[1], FW * CPB + 3);
      end

      // Reset in the middle of the data bits of 0x3C; 0x99 must follow normally.
      @(negedge rclk);
      r0 = rd_count;
      fifo.push_back(8'h3C);
      fifo.push_back(8'h99);
      n = 0;
      while (!(mon_active && mon_pos == 4 * CPB + 1) && n < 200) begin
         @(negedge rclk);
         n++;
      end
      chk("rst_reach_data_timeout", int'(n < 200), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_tx", int'(ifc.tx), 1);
      chk("rst_mid_rd", int'(ifc.rd), 0);
      chk("rst_mid_busy", int'(ifc.busy), 0);
      repeat (2) @(negedge rclk);
      rst_n = 1'b1;
      wait_quiet("after_rst", 1'b1, 200);
      chk("after_rst_rd_pulses", rd_count - r0, 2);

      // Drop en during START of 0x55: frame finishes, 0x66 stays queued.
      @(negedge rclk);
      r0 = rd_count;
      fifo.push_back(8'h55);
      fifo.push_back(8'h66);
      n = 0;
      while (!(mon_active && mon_pos == 1) && n < 50) begin
         @(negedge rclk);
         n++;
      end
      chk("en_drop_reach_start_timeout", int'(n < 50), 1);
      ifc.en = 1'b0;
      wait_quiet("en_drop", 1'b0, 200);
      repeat (30) @(negedge rclk);
      chk("en_drop_rd_pulses", rd_count - r0, 1);
      chk("en_drop_fifo_left", fifo.size(), 1);
      chk("en_drop_busy", int'(ifc.busy), 0);
      ifc.en = 1'b1;
      wait_quiet("en_restore", 1'b1, 200);
      chk("en_restore_rd_pulses", rd_count - r0, 2);

      // Random bursts.
      for (int it = 0; it < 6; it++) begin
         @(negedge rclk);
         r0 = rd_count;
         n = $urandom_range(1, 3);
         for (int j = 0; j < n; j++) fifo.push_back(DW'($urandom));
         wait_quiet("rand", 1'b1, 600);
         chk("rand_rd_pulses", rd_count - r0, n);
      end
      chk("frames_total", frames_done, rd_count - 1);
      chk("scoreboard_empty", exp_q.size(), 0);

      // Full-rate instance: one 0x5A frame, every bit 434 cycles.
      f2 = {1'b1, 8'h5A, 1'b0};
      @(negedge rclk);
      ifc2.en = 1'b1;
      n = 0;
      while (ifc2.tx && n < 20) begin
         @(negedge rclk);
         n++;
      end
      chk("cpb434_start_timeout", int'(n < 20), 1);
      chk("cpb434_start_latency", n, 3);
      for (int p = 0; p <= FW * CPB2; p++) begin
         if (p > 0) @(negedge rclk);
         k = p / CPB2;
         if (p == FW * CPB2) begin
            chk("cpb434_busy_end", int'(ifc2.busy), 0);
         end else if (p % CPB2 == 0 || p % CPB2 == CPB2 - 1) begin
            chk($sformatf("cpb434_bit%0d_off%0d", k, p % CPB2), int'(ifc2.tx), int'(f2[k]));
            if (p == FW * CPB2 - 1) chk("cpb434_busy_last", int'(ifc2.busy), 1);
         end
      end
      ifc2.en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fifo_uart_drain.md
# fifo_uart_drain

Read-side consumer for the camera pixel FIFO. Whenever the FIFO reports data and the block is enabled, it pops one word with a single-cycle `rd` pulse and captures the word from the FIFO's registered output. It then serialises the word on a UART 8N1-style line (start bit, data LSB first, stop bit) and repeats until the FIFO is empty. It sits on the FIFO's read clock domain and is the only driver of the FIFO's `rd` input.

## Interface
Parameters:
- `dato_width`, 8: width of a FIFO word and number of data bits per frame.
- `clks_per_bit`, 434: `rclk` cycles per UART bit (50 MHz / 115200). Must be ≥ 2.

Ports:
- `rclk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  Asynchronous, active-low reset (asserted at 0).
- `en`  in  1  Drain enable. Sampled only in IDLE.
- `empy`  in  1  FIFO empty flag. Must be stable around `rclk` edges.
- `datin`  in  `dato_width`  FIFO read data (FIFO `datout`), valid the cycle after `rd` is sampled.
- `rd`  out  1  FIFO pop request, registered, one cycle wide.
- `tx`  out  1  Serial line, idle high.
- `busy`  out  1  High in every state except IDLE.

## Operation
- States:
  - IDLE → REQ when `en`=1 and `empy`=0. Otherwise stay in IDLE.
  - REQ: `rd`=1 for exactly this one cycle. Always → LOAD.
  - LOAD: `rd`=0. Always → START. On exit, the shift register loads `datin` and `tx` goes to 0.
  - START: lasts `clks_per_bit` cycles → DATA.
  - DATA: lasts `dato_width` bits × `clks_per_bit` cycles; `tx` = shift[0], then shift right each bit → STOP.
  - STOP: lasts `clks_per_bit` cycles with `tx`=1 → IDLE.
- `rd` is never asserted while `empy`=1 at the IDLE decision edge. `rd` is never asserted twice per frame.
- Counters:
  - Baud counter is `$clog2(clks_per_bit)` bits wide. It counts 0..`clks_per_bit`−1 and wraps to 0 at each bit boundary.
  - Bit counter is `$clog2(dato_width+1)` bits wide. It counts 0..`dato_width`−1 in DATA.
- `en` falling mid-frame: the current frame completes; no further pop happens.
- `empy` changing outside IDLE: ignored.
- Reset, including mid-frame:
  - `tx`=1, `rd`=0, `busy`=0, state IDLE, all counters and the shift register 0.
  - The in-flight word is lost. Popped data is not restored.

## Timing
- Decision edge E0 (IDLE, `en`=1, `empy`=0): `rd`=1 after E0.
- E1: FIFO samples `rd` and updates `datout`; `rd`=0 after E1.
- E2: capture `datin`; `tx` falls after E2. Latency from E0 to start bit is 2 cycles.
- Frame length from `tx` fall to return to IDLE: (`dato_width`+2)·`clks_per_bit` cycles.
- Back-to-back words: the next `rd` pulse is asserted after the first IDLE edge. Minimum spacing between start bits is (`dato_width`+2)·`clks_per_bit`+3 cycles; line stays high in the gap.
- `busy` rises after E0 and falls after the final STOP cycle.

## Structure
- Shared package `fifo_uart_pkg`:
  - state enum (IDLE, REQ, LOAD, START, DATA, STOP);
  - default constants `DATO_WIDTH_DEF`=8, `CLKS_PER_BIT_DEF`=434.
- Sub-module `baud_tick`:
  - parameter `clks_per_bit`; inputs `rclk`, `rst`, `clr`;
  - output `tick`, one cycle high every `clks_per_bit` cycles after `clr`.
  - Cleared on LOAD exit.

## Test plan
Run with `clks_per_bit`=4 and `dato_width`=8 unless stated.
- Reset, then `en`=1, `empy`=1 for 50 cycles → `rd` never 1, `tx`=1, `busy`=0.
- FIFO holds 0xA5, `en`=1 → exactly one `rd` pulse. `tx` falls 2 cycles after the decision edge, then sends 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. `busy` falls after 40 cycles of frame.
- FIFO holds 0x01, 0x80, 0xFF → three frames in order, 3 `rd` pulses, start bits 43 cycles apart. IDLE after the third frame.
- Assert `rst` low mid-DATA of 0x3C → `tx`=1 and `rd`=0 immediately. After release, the remaining FIFO word is sent normally.
- `en` dropped during START of 0x55 → frame completes correctly. No further `rd` pulse while the FIFO is still non-empty.
- `clks_per_bit`=434 → each bit is 434 cycles. The full 8-bit frame is 4340 cycles.
